// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine for mult, multu, div and divu.
// It works on operand magnitudes, then applies sign correction in a final FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_div, neg_lo, neg_hi;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               sgn, a_neg, b_neg, accept, zero_div, done_nxt;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_new, q_fix, r_fix;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] p_fix;

    assign sgn      = ~op[0];
    assign a_neg    = sgn & a[WIDTH-1];
    assign b_neg    = sgn & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign accept   = (state == IDLE) && start;
    assign zero_div = accept && op[1] && (b == '0);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (accept && !zero_div) state_nxt = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (zero_div) done_nxt = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            div_zero <= zero_div;
        end
    end

    // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    assign rem_new   = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign p_fix     = neg_lo ? -acc : acc;
    assign q_fix     = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept && !zero_div) begin
                    is_div <= op[1];
                    mag_b  <= b_mag;
                    acc    <= {{WIDTH{1'b0}}, a_mag};
                    neg_lo <= a_neg ^ b_neg;
                    neg_hi <= a_neg;
                    cnt    <= '0;
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) acc <= {rem_new, acc[WIDTH-2:0], ~div_diff[WIDTH+1]};
                    else        acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= p_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit at WIDTH=32 and WIDTH=8, checking against a plain-arithmetic model.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset, start32, start8;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] prev32 = '0;
    logic [63:0] prev8  = '0;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) u32 (
        .clock(clock), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
    );
    mult_div_unit #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {hi, lo} straight from integer arithmetic on the w-bit operands
    function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                          input logic [31:0] av, input logic [31:0] bv);
        longint unsigned mask, ua, ub, pu, rh, rl;
        longint sa, sb, ps, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, av} & mask;
        ub = {32'd0, bv} & mask;
        sa = ua[w-1] ? $signed(ua) - (longint'(1) << w) : $signed(ua);
        sb = ub[w-1] ? $signed(ub) - (longint'(1) << w) : $signed(ub);
        rh = 0;
        rl = 0;
        case (o)
            2'd0: begin ps = sa * sb; pu = ps; rh = (pu >> w) & mask; rl = pu & mask; end
            2'd1: begin pu = ua * ub; rh = (pu >> w) & mask; rl = pu & mask; end
            2'd2: begin q = sa / sb; r = sa % sb; rh = r & mask; rl = q & mask; end
            default: begin rh = ua % ub; rl = ua / ub; end
        endcase
        return {rh[31:0], rl[31:0]};
    endfunction

    // Caller sits on a negedge; start is driven there and sampled at the next edge (E0).
    task automatic run_op(input int w, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int poke, output int lat, output int bcnt);
        op = o; a = av; b = bv;
        if (w == 32) start32 = 1'b1; else start8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start32 = 1'b0; start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!(w == 32 ? done32 : done8) && lat < 200) begin
            if (w == 32 ? busy32 : busy8) bcnt++;
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (poke > 0 && lat == poke - 1) begin
                if (w == 32) start32 = 1'b1; else start8 = 1'b1;
                op = 2'd2; a = 100; b = 3;
            end
            @(negedge clock);
            start32 = 1'b0; start8 = 1'b0;
            lat++;
        end
    endtask

    task automatic test_op(input int w, input logic [1:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input int poke = 0);
        logic [63:0] e;
        logic [31:0] m;
        logic        dz;
        int          lat, bc;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        dz = o[1] && ((bv & m) == 0);
        run_op(w, o, av, bv, poke, lat, bc);
        if (dz) e = (w == 32) ? prev32 : prev8;
        else    e = model(w, o, av, bv);
        if (w == 32) prev32 = e; else prev8 = e;
        chk("latency", 64'(lat), dz ? 64'd0 : 64'(w + 1));
        chk("busy_cycles", 64'(bc), dz ? 64'd0 : 64'(w + 1));
        chk("hi", (w == 32) ? 64'(hi32) : 64'(hi8), 64'(e[63:32]));
        chk("lo", (w == 32) ? 64'(lo32) : 64'(lo8), 64'(e[31:0]));
        chk("div_zero", 64'(w == 32 ? dz32 : dz8), 64'(dz));
    endtask

    initial begin
        int k, dcount;
        logic [1:0]  o;
        logic [31:0] bv;
        reset = 1'b1; start32 = 1'b0; start8 = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        chk("rst_hi32", 64'(hi32), 64'd0);
        chk("rst_lo32", 64'(lo32), 64'd0);
        chk("rst_flags32", {61'd0, busy32, done32, dz32}, 64'd0);
        chk("rst_out8", {40'd0, hi8, lo8, 5'd0, busy8, done8, dz8}, 64'd0);
        reset = 1'b0;

        test_op(32, 2'd0, -32'sd3, 32'd5);
        test_op(32, 2'd1, 32'hFFFF_FFFF, 32'd2);
        test_op(32, 2'd0, 32'hFFFF_FFFF, 32'd2);
        test_op(32, 2'd2, -32'sd7, 32'd2);
        test_op(32, 2'd3, 32'd7, 32'd2);
        test_op(32, 2'd3, 32'd7, 32'd0);
        test_op(32, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        test_op(32, 2'd0, 32'd6, 32'd7, 10);
        test_op(32, 2'd0, 32'd2, 32'd3);
        @(negedge clock);
        chk("done_one_cycle", 64'(done32), 64'd0);

        // Reset lands on edge E15 of a multu: abort, clear results, no done afterwards.
        op = 2'd1; a = $urandom; b = $urandom; start32 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start32 = 1'b0;
        for (k = 0; k < 14; k++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_hilo", {hi32, lo32}, 64'd0);
        reset = 1'b0;
        prev32 = '0;
        dcount = 0;
        for (k = 0; k < 40; k++) begin
            if (done32) dcount++;
            @(negedge clock);
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        test_op(32, 2'd1, 32'd12345, 32'd678);

        test_op(8, 2'd0, 32'h80, 32'h80);
        test_op(8, 2'd2, 32'hF9, 32'd2);
        test_op(8, 2'd2, 32'h80, 32'hFF);
        test_op(8, 2'd3, 32'd7, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o  = 2'($urandom_range(0, 3));
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20));
            test_op(32, o, $urandom, bv);
        end
        for (int i = 0; i < 30; i++) begin
            o  = 2'($urandom_range(0, 3));
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            test_op(8, o, $urandom, bv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
